// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready memory port and
// buffers words with their PC for decode. Optional perf counters: `define IFETCH_PERF_EN.
module ifetch #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [63:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [63:0]        pc_r;
  logic [63:0]        pc_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [31:0]        fifo_word_r [FIFO_DEPTH];
  logic [63:0]        fifo_pc_r   [FIFO_DEPTH];
  logic               req_valid_r;
  logic               req_valid_s;
  logic               inst_valid_r;
  logic               req_fire_s;
  logic               resp_fire_s;
  logic               push_s;
  logic               pop_s;

  // Next-state, PC, FIFO occupancy and next request-valid; redirect overrides everything
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    count_s     = count_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    req_fire_s  = req_valid_r & imem_req_ready;
    resp_fire_s = imem_resp_valid & (state_r != ST_FETCH);
    if (redirect_valid) begin
      pc_s    = redirect_pc & ~64'd3;
      count_s = {CNT_W{1'b0}};
      if (resp_fire_s) begin
        state_s = ST_FETCH;
      end else if ((state_r != ST_FETCH) || req_fire_s) begin
        state_s = ST_DROP;
      end else begin
        state_s = ST_FETCH;
      end
    end else begin
      pop_s = inst_valid_r & inst_ready;
      case (state_r)
        ST_FETCH: begin
          if (req_fire_s) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (resp_fire_s) begin
            push_s  = 1'b1;
            pc_s    = pc_r + 64'd4;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (resp_fire_s) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_DROP;
          end
        end
        default: begin
          state_s = ST_FETCH;
        end
      endcase
      if (push_s && !pop_s) begin
        count_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_s = count_r - CNT_W'(1);
      end else begin
        count_s = count_r;
      end
    end
    // Outside FETCH a request is in flight, so the credit test reduces to FIFO room
    req_valid_s = (state_s == ST_FETCH) && (count_s < CNT_W'(FIFO_DEPTH));
  end

  // Control state, PC, pointers and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      count_r      <= {CNT_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      count_r      <= count_s;
      req_valid_r  <= req_valid_s;
      inst_valid_r <= (count_s != {CNT_W{1'b0}});
      if (redirect_valid) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
      end
    end
  end

  // Fetch buffer storage; cleared on reset so inst/inst_pc read zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_word_r[i] <= 32'd0;
        fifo_pc_r[i]   <= 64'd0;
      end
    end else begin
      if (push_s) begin
        fifo_word_r[wr_ptr_r] <= imem_resp_data;
        fifo_pc_r[wr_ptr_r]   <= pc_r;
      end else begin
        fifo_word_r[wr_ptr_r] <= fifo_word_r[wr_ptr_r];
        fifo_pc_r[wr_ptr_r]   <= fifo_pc_r[wr_ptr_r];
      end
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = {32'd0, fifo_word_r[rd_ptr_r]};
  assign inst_pc        = fifo_pc_r[rd_ptr_r];

`ifdef IFETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  logic [31:0] fetch_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating counters of delivered fetches and redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (push_s) begin
        fetch_cnt_r <= sat_inc(fetch_cnt_r);
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (redirect_valid) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a queue-based fetch model is checked every cycle,
// plus directed scenarios with literal expectations (second instance covers PC wrap).
module tb_ifetch;
  localparam logic [63:0] RPC   = 64'h8000_0000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, resp_valid, redirect_valid, inst_valid, inst_ready;
  logic [63:0] req_addr, redirect_pc, inst, inst_pc;
  logic [31:0] resp_data;
  logic        rst2, req_valid2, req_ready2, resp_valid2, redirect_valid2, inst_valid2, inst_ready2;
  logic [63:0] req_addr2, redirect_pc2, inst2, inst_pc2;
  logic [31:0] resp_data2;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_fetch_cnt2, perf_flush_cnt2;
`endif

  ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  ifetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_ready(req_ready2),
    .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_ready(inst_ready2)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt2), .perf_flush_cnt(perf_flush_cnt2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: any address maps to a fixed word; 8000_0000 holds 0050_0093
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h8050_0093;
  endfunction

  // Reference model: fetch buffer as a queue, plus one in-flight request flag
  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;
  ent_t        m_q[$];
  logic [63:0] m_pc;
  bit          m_out, m_stale, m_started;
  logic [31:0] m_fetch, m_flush;
  bit          check_en;

  // Memory responder state
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          lat_min, lat_max;
  bit          spur_en;

  function automatic void model_reset();
    m_q.delete();
    m_pc      = RPC;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_started = 1'b0;
    m_fetch   = 32'd0;
    m_flush   = 32'd0;
  endfunction

  function automatic bit m_req();
    return m_started && !m_out && (m_q.size() < DEPTH);
  endfunction

  // Advance model and memory across one posedge, then drive the next response
  task automatic tick();
    bit          acc, rfire;
    logic [63:0] pc_pre;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
      mem_pend       = 1'b0;
      resp_valid     = 1'b0;
      redirect_valid = 1'b0;
      return;
    end
    acc    = m_req() && req_ready;
    rfire  = m_out && resp_valid;
    pc_pre = m_pc;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & ~64'd3;
      if (m_flush != 32'hFFFF_FFFF) m_flush++;
      if (rfire) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (m_out || acc) begin
        m_out = 1'b1; m_stale = 1'b1;
      end else begin
        m_out = 1'b0;
      end
    end else begin
      if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
      if (rfire) begin
        if (!m_stale) begin
          m_q.push_back('{pc: m_pc, w: resp_data});
          m_pc = m_pc + 64'd4;
          if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        end
        m_out = 1'b0; m_stale = 1'b0;
      end else if (acc) begin
        m_out = 1'b1; m_stale = 1'b0;
      end
    end
    m_started = 1'b1;
    if (mem_pend && resp_valid) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = pc_pre;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    redirect_valid = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        resp_valid = 1'b1;
        resp_data  = word_of(mem_addr);
      end else begin
        mem_cnt--;
        resp_valid = 1'b0;
      end
    end else begin
      resp_valid = spur_en && ($urandom_range(19, 0) == 0);
      resp_data  = $urandom;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (check_en && rst) begin
      chk("req_valid", 64'(req_valid), 64'(m_req()));
      if (m_req()) chk("req_addr", req_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("inst", inst, {32'd0, m_q[0].w});
        chk("inst_pc", inst_pc, m_q[0].pc);
      end
`ifdef IFETCH_PERF_EN
      chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
      chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    end
  end

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req_ready  = ($urandom_range(3, 0) != 0);
      inst_ready = $urandom_range(1, 0) != 0;
      if ($urandom_range(15, 0) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(3, 0) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
        else redirect_pc = {$urandom, $urandom};
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;
    rst2 = 1'b0; req_ready2 = 1'b1; resp_valid2 = 1'b0; resp_data2 = 32'd0;
    redirect_valid2 = 1'b0; redirect_pc2 = 64'd0; inst_ready2 = 1'b0;
    lat_min = 1; lat_max = 1; spur_en = 1'b0; check_en = 1'b0; mem_pend = 1'b0; mem_cnt = 0;
    mem_addr = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_valid", 64'(req_valid), 64'd0);
    chk("reset inst_valid", 64'(inst_valid), 64'd0);
    chk("reset inst", inst, 64'd0);
    chk("reset inst_pc", inst_pc, 64'd0);

    // Sequential fetch with ready=1 and one-cycle responses, decode stalled
    rst = 1'b1; check_en = 1'b1; req_ready = 1'b1;
    tick();
    chk("t1 first addr", req_addr, 64'h8000_0000);
    chk("t1 first valid", 64'(req_valid), 64'd1);
    tick();
    tick();
    chk("t1 inst", inst, 64'h0000_0000_0050_0093);
    chk("t1 inst_pc", inst_pc, 64'h8000_0000);
    chk("t1 second addr", req_addr, 64'h8000_0004);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2 stalled req", 64'(req_valid), 64'd0);
      chk("t2 head held", inst_pc, 64'h8000_0000);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t2 popped head", inst_pc, 64'h8000_0004);
    chk("t2 resume valid", 64'(req_valid), 64'd1);
    chk("t2 resume addr", req_addr, 64'h8000_0008);

    // Redirect coinciding with a response and a pop
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0203; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t4 flushed", 64'(inst_valid), 64'd0);
    chk("t4 req valid", 64'(req_valid), 64'd1);
    chk("t4 req addr", req_addr, 64'h8000_0200);

    // Redirect while a slow request is outstanding
    lat_min = 3; lat_max = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    chk("t3 drop no req", 64'(req_valid), 64'd0);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      if (req_valid) break;
      tick();
    end
    chk("t3 refetch valid", 64'(req_valid), 64'd1);
    chk("t3 refetch addr", req_addr, 64'h8000_0100);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) break;
      tick();
    end
    chk("t3 inst_pc", inst_pc, 64'h8000_0100);
    chk("t3 inst", inst, {32'd0, word_of(64'h8000_0100)});

    // Randomized traffic
    spur_en = 1'b1; lat_min = 1; lat_max = 3;
    random_run(3000);

    // Reset mid-request with the buffer at its credit limit
    spur_en = 1'b0; inst_ready = 1'b0; req_ready = 1'b1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      if (m_q.size() == DEPTH - 1 && m_out) break;
      tick();
    end
    chk("t6 pre inst_valid", 64'(inst_valid), 64'd1);
    rst = 1'b0; check_en = 1'b0;
    #1;
    chk("t6 req_valid", 64'(req_valid), 64'd0);
    chk("t6 inst_valid", 64'(inst_valid), 64'd0);
    chk("t6 inst", inst, 64'd0);
    chk("t6 inst_pc", inst_pc, 64'd0);
`ifdef IFETCH_PERF_EN
    chk("t6 perf_fetch", 64'(perf_fetch_cnt), 64'd0);
    chk("t6 perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif
    repeat (3) tick();
    rst = 1'b1; check_en = 1'b1; lat_min = 1; lat_max = 3;
    tick();
    chk("t6 refetch valid", 64'(req_valid), 64'd1);
    chk("t6 refetch addr", req_addr, 64'h8000_0000);
    spur_en = 1'b1;
    random_run(800);
    check_en = 1'b0;

    // PC wrap from the top of the address space
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("t5 first valid", 64'(req_valid2), 64'd1);
    chk("t5 first addr", req_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    resp_valid2 = 1'b1; resp_data2 = 32'h1234_5678;
    @(posedge clk); #1;
    resp_valid2 = 1'b0;
    chk("t5 second valid", 64'(req_valid2), 64'd1);
    chk("t5 second addr", req_addr2, 64'd0);
    chk("t5 inst_valid", 64'(inst_valid2), 64'd1);
    chk("t5 inst_pc", inst_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5 inst", inst2, 64'h0000_0000_1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
